// File: rtl/gauss_arb_pkg.sv
// Shared types and helpers for the GaussFilter share arbiter.
package gauss_arb_pkg;

  localparam int DATA_W_DEF = 32'sd24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  typedef logic [DATA_W_DEF-1:0] pix_t;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      if ((64'sd1 << i) < longint'(value)) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/gauss_arb_frame_cnt.sv
// Saturating pixel counter for one frame; reports completion and the final-pixel position.
module gauss_arb_frame_cnt #(
  parameter int FRAME_PIX = 32'sd65536,
  parameter int CNT_W     = 32'sd17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic done,
  output logic last
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(FRAME_PIX);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(FRAME_PIX - 32'sd1);

  logic [CNT_W-1:0] cnt_r;

  // Count transfers, holding at the frame size so a misbehaving peer cannot wrap it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == LIMIT);
  assign last = (cnt_r == LIMIT_M1);

endmodule

// File: rtl/gauss_share_arbiter.sv
// Time-shares one GaussFilter between two pixel requesters, one whole frame per grant,
// alternating round-robin when both are waiting.
module gauss_share_arbiter
  import gauss_arb_pkg::*;
#(
  parameter int FRAME_PIX = 32'sd65536,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = clog2(FRAME_PIX + 32'sd1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              r0_req,
  output logic              r0_gnt,
  input  logic              r0_in_vld,
  output logic              r0_in_busy,
  input  logic [DATA_W-1:0] r0_in_data,
  output logic              r0_out_vld,
  input  logic              r0_out_busy,
  output logic [DATA_W-1:0] r0_out_data,
  input  logic              r1_req,
  output logic              r1_gnt,
  input  logic              r1_in_vld,
  output logic              r1_in_busy,
  input  logic [DATA_W-1:0] r1_in_data,
  output logic              r1_out_vld,
  input  logic              r1_out_busy,
  output logic [DATA_W-1:0] r1_out_data,
  output logic              f_in_vld,
  input  logic              f_in_busy,
  output logic [DATA_W-1:0] f_in_data,
  input  logic              f_out_vld,
  output logic              f_out_busy,
  input  logic [DATA_W-1:0] f_out_data,
  output logic              o_err
);

  arb_state_e        state_r;
  logic              owner_r, last_r, err_r;
  logic [1:0]        gnt_r;
  logic              active_s, in_open_s, next_owner_s;
  logic              in_xfer_s, in_done_s, in_last_s, in_fin_s;
  logic              out_xfer_s, out_done_s, out_last_s, out_fin_s, frame_end_s;
  logic              own_in_vld_s, own_out_busy_s;
  logic [DATA_W-1:0] own_in_data_s;

  assign active_s     = (state_r != ST_IDLE);
  assign in_open_s    = (state_r == ST_STREAM) & ~in_done_s;
  assign next_owner_s = (r0_req & r1_req) ? ~last_r : r1_req;
  assign in_xfer_s    = f_in_vld & ~f_in_busy;
  assign out_xfer_s   = active_s & f_out_vld & ~f_out_busy;
  // "fin" means the frame side is complete once this edge lands
  assign in_fin_s     = in_done_s | (in_xfer_s & in_last_s);
  assign out_fin_s    = out_done_s | (out_xfer_s & out_last_s);
  assign frame_end_s  = active_s & in_fin_s & out_fin_s;

  assign r0_gnt = gnt_r[0];
  assign r1_gnt = gnt_r[1];
  assign o_err  = err_r;

  gauss_arb_frame_cnt #(.FRAME_PIX(FRAME_PIX), .CNT_W(CNT_W)) u_in_cnt (
    .clk(i_clk), .rst_n(i_rst), .clr(frame_end_s), .inc(in_xfer_s),
    .done(in_done_s), .last(in_last_s)
  );

  gauss_arb_frame_cnt #(.FRAME_PIX(FRAME_PIX), .CNT_W(CNT_W)) u_out_cnt (
    .clk(i_clk), .rst_n(i_rst), .clr(frame_end_s), .inc(out_xfer_s),
    .done(out_done_s), .last(out_last_s)
  );

  // Pick the current owner's requester-side signals
  always_comb begin
    if (owner_r) begin
      own_in_vld_s   = r1_in_vld;
      own_in_data_s  = r1_in_data;
      own_out_busy_s = r1_out_busy;
    end else begin
      own_in_vld_s   = r0_in_vld;
      own_in_data_s  = r0_in_data;
      own_out_busy_s = r0_out_busy;
    end
  end

  // Zero-latency routing between owner and filter; the non-owner is always held off
  always_comb begin
    f_in_vld    = 1'b0;
    f_in_data   = {DATA_W{1'b0}};
    f_out_busy  = 1'b1;
    r0_in_busy  = 1'b1;
    r1_in_busy  = 1'b1;
    r0_out_vld  = 1'b0;
    r1_out_vld  = 1'b0;
    r0_out_data = {DATA_W{1'b0}};
    r1_out_data = {DATA_W{1'b0}};
    if (active_s) begin
      f_in_vld   = own_in_vld_s & in_open_s;
      f_in_data  = own_in_data_s;
      f_out_busy = own_out_busy_s;
      if (owner_r) begin
        r1_in_busy  = ~in_open_s | f_in_busy;
        r1_out_vld  = f_out_vld;
        r1_out_data = f_out_data;
      end else begin
        r0_in_busy  = ~in_open_s | f_in_busy;
        r0_out_vld  = f_out_vld;
        r0_out_data = f_out_data;
      end
    end else begin
      f_out_busy = 1'b1;
    end
  end

  // Frame sequencing, round-robin pointer and sticky orphan-output flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      gnt_r   <= 2'b00;
      err_r   <= 1'b0;
    end else begin
      if (!active_s && f_out_vld) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (r0_req || r1_req) begin
            owner_r <= next_owner_s;
            gnt_r   <= next_owner_s ? 2'b10 : 2'b01;
            state_r <= ST_STREAM;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_STREAM, ST_DRAIN: begin
          if (frame_end_s) begin
            last_r  <= owner_r;
            gnt_r   <= 2'b00;
            state_r <= ST_IDLE;
          end else if (in_fin_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          gnt_r   <= 2'b00;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_share_arbiter.sv
// Directed bench for gauss_share_arbiter with a 16-pixel frame and a 3-cycle filter model.
module tb_gauss_share_arbiter;
  import gauss_arb_pkg::*;

  localparam int FP = 16;
  localparam logic [23:0] MASK = 24'h5A5A5A;

  logic i_clk, i_rst;
  logic r0_req, r0_gnt, r0_in_vld, r0_in_busy, r0_out_vld, r0_out_busy;
  logic r1_req, r1_gnt, r1_in_vld, r1_in_busy, r1_out_vld, r1_out_busy;
  pix_t r0_in_data, r0_out_data, r1_in_data, r1_out_data;
  logic f_in_vld, f_in_busy, f_out_vld, f_out_busy, o_err;
  pix_t f_in_data, f_out_data;

  gauss_share_arbiter #(.FRAME_PIX(FP), .DATA_W(24)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_in_vld(r0_in_vld), .r0_in_busy(r0_in_busy),
    .r0_in_data(r0_in_data), .r0_out_vld(r0_out_vld), .r0_out_busy(r0_out_busy),
    .r0_out_data(r0_out_data),
    .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_in_vld(r1_in_vld), .r1_in_busy(r1_in_busy),
    .r1_in_data(r1_in_data), .r1_out_vld(r1_out_vld), .r1_out_busy(r1_out_busy),
    .r1_out_data(r1_out_data),
    .f_in_vld(f_in_vld), .f_in_busy(f_in_busy), .f_in_data(f_in_data),
    .f_out_vld(f_out_vld), .f_out_busy(f_out_busy), .f_out_data(f_out_data),
    .o_err(o_err)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0, last_out_cyc = 0, busy_viol = 0, leak_viol = 0;
  int idx0 = 0, idx1 = 0, n0 = 0, n1 = 0;
  logic err_inject = 1'b0;
  pix_t src0 [0:31];
  pix_t src1 [0:31];
  pix_t fq_d [$];
  int   fq_t [$];
  pix_t rx0_q [$];
  pix_t rx1_q [$];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    r0_in_vld  = (idx0 < n0);
    r0_in_data = (idx0 < n0) ? src0[idx0] : 24'h000000;
    r1_in_vld  = (idx1 < n1);
    r1_in_data = (idx1 < n1) ? src1[idx1] : 24'h000000;
    if (fq_d.size() > 0) begin
      f_out_vld  = err_inject || (cyc >= fq_t[0]);
      f_out_data = fq_d[0];
    end else begin
      f_out_vld  = err_inject;
      f_out_data = 24'h000000;
    end
  endtask

  // One clock: sample handshakes before the edge, update models after it
  task automatic tick();
    logic s0, s1, fin_x, fout_x, o0, o1;
    pix_t fin_d, o0_d, o1_d;
    #1;
    s0 = r0_in_vld && !r0_in_busy;
    s1 = r1_in_vld && !r1_in_busy;
    fin_x = f_in_vld && !f_in_busy;
    fin_d = f_in_data;
    fout_x = f_out_vld && !f_out_busy;
    o0 = r0_out_vld && !r0_out_busy;
    o0_d = r0_out_data;
    o1 = r1_out_vld && !r1_out_busy;
    o1_d = r1_out_data;
    if (!r0_gnt && (!r0_in_busy || r0_out_vld)) busy_viol++;
    if (!r1_gnt && (!r1_in_busy || r1_out_vld)) busy_viol++;
    if (r0_gnt && idx0 >= FP && (f_in_vld || !r0_in_busy)) leak_viol++;
    if (r1_gnt && idx1 >= FP && (f_in_vld || !r1_in_busy)) leak_viol++;
    @(posedge i_clk);
    cyc++;
    if (fout_x && fq_d.size() > 0) begin
      void'(fq_d.pop_front());
      void'(fq_t.pop_front());
    end
    if (fin_x) begin
      fq_d.push_back(fin_d ^ MASK);
      fq_t.push_back(cyc + 3);
    end
    if (s0) idx0++;
    if (s1) idx1++;
    if (o0) begin
      rx0_q.push_back(o0_d);
      if (rx0_q.size() == FP) last_out_cyc = cyc;
    end
    if (o1) begin
      rx1_q.push_back(o1_d);
      if (rx1_q.size() == FP) last_out_cyc = cyc;
    end
    #1;
    drive_inputs();
  endtask

  task automatic wait_idle(input int sel, input int max_cyc);
    int k;
    k = 0;
    while (((sel == 0) ? r0_gnt : r1_gnt) && k < max_cyc) begin
      tick();
      k++;
    end
    check("idle_reached", (sel == 0) ? r0_gnt : r1_gnt, 32'd0);
  endtask

  task automatic check_rx(input string tag, input int sel, input logic [23:0] base);
    logic [31:0] obs;
    pix_t p;
    check({tag, "_count"}, (sel == 0) ? rx0_q.size() : rx1_q.size(), FP);
    for (int i = 0; i < FP; i++) begin
      if (sel == 0) obs = (i < rx0_q.size()) ? {8'h00, rx0_q[i]} : 32'hDEADBEEF;
      else          obs = (i < rx1_q.size()) ? {8'h00, rx1_q[i]} : 32'hDEADBEEF;
      p = base + 24'(i);
      check(tag, obs, {8'h00, p ^ MASK});
    end
  endtask

  task automatic load_src(input int sel, input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) src0[i] = base + 24'(i);
      else          src1[i] = base + 24'(i);
    end
    if (sel == 0) begin idx0 = 0; n0 = n; end
    else          begin idx1 = 0; n1 = n; end
    drive_inputs();
  endtask

  initial begin
    int k, base;
    i_rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    r0_out_busy = 1'b0; r1_out_busy = 1'b0; f_in_busy = 1'b0;
    drive_inputs();
    repeat (3) tick();
    check("rst_r0_gnt", r0_gnt, 0);
    check("rst_r1_gnt", r1_gnt, 0);
    check("rst_r0_in_busy", r0_in_busy, 1);
    check("rst_r1_in_busy", r1_in_busy, 1);
    check("rst_out_vld", {r1_out_vld, r0_out_vld}, 0);
    check("rst_f_in_vld", f_in_vld, 0);
    check("rst_f_out_busy", f_out_busy, 1);
    check("rst_err", o_err, 0);
    i_rst = 1'b1;
    tick();

    // Single requester, 17 pixels offered: only 16 may be consumed
    load_src(0, 24'h000001, FP + 1);
    r0_req = 1'b1;
    #1 check("t1_gnt_pre", r0_gnt, 0);
    tick();
    check("t1_gnt", r0_gnt, 1);
    check("t1_r1_gnt", r1_gnt, 0);
    r0_req = 1'b0;
    wait_idle(0, 60);
    check("t1_idle_at_last_out", cyc - last_out_cyc, 0);
    check_rx("t1_data", 0, 24'h000001);
    check("t3_17th_held", idx0, FP);
    check("t3_busy_after", r0_in_busy, 1);
    repeat (2) tick();
    check("t1_no_regrant", r0_gnt, 0);

    // Concurrent requests after reset: r0, then r1, then r0 again
    i_rst = 1'b0;
    fq_d.delete(); fq_t.delete();
    tick();
    i_rst = 1'b1;
    rx0_q.delete(); rx1_q.delete();
    load_src(0, 24'h000100, FP);
    load_src(1, 24'h000200, FP);
    r0_req = 1'b1; r1_req = 1'b1;
    tick();
    check("t2_first_r0", r0_gnt, 1);
    check("t2_first_not_r1", r1_gnt, 0);
    wait_idle(0, 60);
    check_rx("t2_r0_data", 0, 24'h000100);
    check("t2_r1_nothing", rx1_q.size(), 0);
    tick();
    check("t2_second_r1", r1_gnt, 1);
    check("t2_second_not_r0", r0_gnt, 0);

    // Owner stalls its output for 5 cycles while draining
    k = 0;
    while (idx1 < FP && k < 40) begin tick(); k++; end
    check("t4_inputs_done", idx1, FP);
    base = rx1_q.size();
    r1_out_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_f_out_busy", f_out_busy, 1);
    end
    check("t4_frozen", rx1_q.size(), base);
    check("t4_held_vld", r1_out_vld, 1);
    r1_out_busy = 1'b0;
    wait_idle(1, 60);
    check_rx("t4_r1_data", 1, 24'h000200);
    tick();
    check("t2_third_r0", r0_gnt, 1);
    check("t2_third_not_r1", r1_gnt, 0);

    // Asynchronous reset mid-frame at in_cnt 7
    load_src(0, 24'h000300, FP);
    k = 0;
    while (idx0 < 7 && k < 40) begin tick(); k++; end
    check("t5_at_seven", idx0, 7);
    #2;
    i_rst = 1'b0;
    fq_d.delete(); fq_t.delete();
    drive_inputs();
    #1;
    check("t5_gnt", {r1_gnt, r0_gnt}, 0);
    check("t5_r0_in_busy", r0_in_busy, 1);
    check("t5_r1_in_busy", r1_in_busy, 1);
    check("t5_f_out_busy", f_out_busy, 1);
    check("t5_f_in_vld", f_in_vld, 0);
    tick();
    i_rst = 1'b1;
    rx0_q.delete(); rx1_q.delete();
    load_src(0, 24'h000400, FP);
    tick();
    check("t5_r0_prio", r0_gnt, 1);
    check("t5_not_r1", r1_gnt, 0);
    r0_req = 1'b0; r1_req = 1'b0;
    wait_idle(0, 60);
    check("t5_full_frame_in", idx0, FP);
    check_rx("t5_data", 0, 24'h000400);

    // Orphan filter output in IDLE
    tick();
    check("t6_err_before", o_err, 0);
    err_inject = 1'b1;
    drive_inputs();
    #1;
    check("t6_no_out_vld", {r1_out_vld, r0_out_vld}, 0);
    tick();
    check("t6_err_set", o_err, 1);
    err_inject = 1'b0;
    drive_inputs();
    repeat (3) tick();
    check("t6_err_sticky", o_err, 1);
    check("t6_still_idle", {r1_gnt, r0_gnt}, 0);
    i_rst = 1'b0;
    #1 check("t6_err_cleared", o_err, 0);
    tick();
    i_rst = 1'b1;

    check("mon_non_owner_blocked", busy_viol, 0);
    check("mon_no_extra_input", leak_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
